// File: rtl/prog_mem_arbiter.sv
// Arbitrates the single-port program memory between instruction fetch (F) and
// the boot/debug loader (L): one access per cycle, registered responses.
module prog_mem_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                f_req_i,
  input  logic [DATA_WIDTH-1:0]               f_addr_i,
  output logic                                f_gnt_o,
  output logic                                f_rvalid_o,
  output logic [DATA_WIDTH-1:0]               f_rdata_o,
  output logic                                f_err_o,
  input  logic                                l_req_i,
  input  logic                                l_we_i,
  input  logic                                l_lock_i,
  input  logic [DATA_WIDTH-1:0]               l_addr_i,
  input  logic [DATA_WIDTH-1:0]               l_wdata_i,
  output logic                                l_gnt_o,
  output logic                                l_rvalid_o,
  output logic [DATA_WIDTH-1:0]               l_rdata_o,
  output logic                                l_err_o,
  output logic [$clog2(MEMORY_DEPTH)-1:0]     mem_addr_o,
  output logic                                mem_we_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_F = 2'd1,
    ACC_L = 2'd2
  } state_t;

  // Returns {error, word index}; below-base addresses are caught by the
  // explicit compare, so the wrapped offset never masks them.
  function automatic logic [IDX_W:0] f_decode(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] off;
    logic                  err;
    off = addr - BASE_ADDR;
    err = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (off >= SPAN);
    return {err, off[IDX_W+1:2]};
  endfunction

  state_t                r_state;
  logic                  r_f_gnt;
  logic                  r_l_gnt;
  logic                  r_err;
  logic                  r_we;
  logic [IDX_W-1:0]      r_mem_addr;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_f_rvalid;
  logic [DATA_WIDTH-1:0] r_f_rdata;
  logic                  r_f_err;
  logic                  r_l_rvalid;
  logic [DATA_WIDTH-1:0] r_l_rdata;
  logic                  r_l_err;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_lat_addr;
  logic                  w_lat_we;
  logic [DATA_WIDTH-1:0] w_lat_wdata;
  logic [IDX_W:0]        w_dec;
  logic                  w_dec_err;
  logic [IDX_W-1:0]      w_dec_idx;
  logic                  w_acc_nxt;

  // Next-state arbitration: fetch wins from IDLE, a locked loader burst
  // holds the memory, and fetch never gets two grants in a row.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE: begin
        if (f_req_i) begin
          w_state_nxt = ACC_F;
        end else if (l_req_i) begin
          w_state_nxt = ACC_L;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACC_F: begin
        if (l_req_i) begin
          w_state_nxt = ACC_L;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACC_L: begin
        if (l_lock_i && l_req_i) begin
          w_state_nxt = ACC_L;
        end else if (f_req_i) begin
          w_state_nxt = ACC_F;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Selects the request that is latched on the edge entering an access state.
  always_comb begin
    w_lat_addr  = '0;
    w_lat_we    = 1'b0;
    w_lat_wdata = '0;
    case (w_state_nxt)
      ACC_F: begin
        w_lat_addr = f_addr_i;
      end
      ACC_L: begin
        w_lat_addr  = l_addr_i;
        w_lat_we    = l_we_i;
        w_lat_wdata = l_wdata_i;
      end
      default: begin
        w_lat_addr = '0;
      end
    endcase
  end

  assign w_dec     = f_decode(w_lat_addr);
  assign w_dec_err = w_dec[IDX_W];
  assign w_dec_idx = w_dec[IDX_W-1:0];
  assign w_acc_nxt = (w_state_nxt != IDLE);

  // State and latched access; memory-side outputs are registered so they
  // are valid for the whole grant cycle and cleared on errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_f_gnt     <= 1'b0;
      r_l_gnt     <= 1'b0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_f_gnt     <= (w_state_nxt == ACC_F);
      r_l_gnt     <= (w_state_nxt == ACC_L);
      r_err       <= w_acc_nxt && w_dec_err;
      r_we        <= w_lat_we;
      r_mem_addr  <= (w_acc_nxt && !w_dec_err) ? w_dec_idx : '0;
      r_mem_we    <= w_lat_we && !w_dec_err;
      r_mem_wdata <= (w_lat_we && !w_dec_err) ? w_lat_wdata : '0;
    end
  end

  // Response registers: capture combinational memory data at the end of
  // the grant cycle; errored accesses and writes return zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_f_err    <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_l_rdata  <= '0;
      r_l_err    <= 1'b0;
    end else begin
      r_f_rvalid <= (r_state == ACC_F);
      r_f_rdata  <= ((r_state == ACC_F) && !r_err) ? mem_rdata_i : '0;
      r_f_err    <= (r_state == ACC_F) && r_err;
      r_l_rvalid <= (r_state == ACC_L);
      r_l_rdata  <= ((r_state == ACC_L) && !r_err && !r_we) ? mem_rdata_i : '0;
      r_l_err    <= (r_state == ACC_L) && r_err;
    end
  end

  assign f_gnt_o     = r_f_gnt;
  assign l_gnt_o     = r_l_gnt;
  assign mem_addr_o  = r_mem_addr;
  assign mem_we_o    = r_mem_we;
  assign mem_wdata_o = r_mem_wdata;
  assign f_rvalid_o  = r_f_rvalid;
  assign f_rdata_o   = r_f_rdata;
  assign f_err_o     = r_f_err;
  assign l_rvalid_o  = r_l_rvalid;
  assign l_rdata_o   = r_l_rdata;
  assign l_err_o     = r_l_err;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a behavioural program memory.
module tb_prog_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_gnt_o;
  logic        f_rvalid_o;
  logic [31:0] f_rdata_o;
  logic        f_err_o;
  logic        l_req_i;
  logic        l_we_i;
  logic        l_lock_i;
  logic [31:0] l_addr_i;
  logic [31:0] l_wdata_i;
  logic        l_gnt_o;
  logic        l_rvalid_o;
  logic [31:0] l_rdata_o;
  logic        l_err_o;
  logic [4:0]  mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [32];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          we_count = 0;
  int          pulse_cnt;

  prog_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
    .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_lock_i(l_lock_i),
    .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i), .l_gnt_o(l_gnt_o),
    .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o), .l_err_o(l_err_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o];

  // Program memory: preloaded with 0x1000_00ii while reset is held.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
      we_count <= we_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req_i = 1'b0; f_addr_i = 32'h0; l_req_i = 1'b0; l_we_i = 1'b0;
    l_lock_i = 1'b0; l_addr_i = 32'h0; l_wdata_i = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"}, {24'h0, f_gnt_o, f_rvalid_o, f_err_o, l_gnt_o,
              l_rvalid_o, l_err_o, mem_we_o, 1'b0}, 32'h0);
    check_val({tag, "_frd"}, f_rdata_o, 32'h0);
    check_val({tag, "_lrd"}, l_rdata_o, 32'h0);
    check_val({tag, "_madr"}, {27'h0, mem_addr_o}, 32'h0);
    check_val({tag, "_mwd"}, mem_wdata_o, 32'h0);
  endtask

  // Single fetch: grant + index one cycle after request, response the next.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [4:0] idx,
                       input logic [31:0] data, input logic err);
    f_req_i = 1'b1; f_addr_i = addr;
    tick();
    f_req_i = 1'b0;
    check_val({tag, "_gnt"}, {31'h0, f_gnt_o}, 32'h1);
    check_val({tag, "_we"}, {31'h0, mem_we_o}, 32'h0);
    check_val({tag, "_idx"}, {27'h0, mem_addr_o}, {27'h0, idx});
    tick();
    check_val({tag, "_rv"}, {31'h0, f_rvalid_o}, 32'h1);
    check_val({tag, "_err"}, {31'h0, f_err_o}, {31'h0, err});
    check_val({tag, "_rd"}, f_rdata_o, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout 0 expected finish 1");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    check_all_zero("rst_init");
    reset = 1'b1;
    tick();

    // Reset in the middle of a fetch grant: outputs clear at once, no response.
    f_req_i = 1'b1; f_addr_i = 32'h0040_0008;
    tick();
    f_req_i = 1'b0;
    check_val("midrst_gnt", {31'h0, f_gnt_o}, 32'h1);
    #2 reset = 1'b0;
    #1 check_all_zero("midrst");
    tick();
    check_val("midrst_norv", {31'h0, f_rvalid_o}, 32'h0);
    reset = 1'b1;
    fetch("rst_f1", 32'h0040_0004, 5'd1, 32'h1000_0001, 1'b0);

    // Contention: fetch first, loader read next cycle.
    f_req_i = 1'b1; f_addr_i = 32'h0040_0000;
    l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h0040_0008;
    tick();
    f_req_i = 1'b0;
    check_val("ct_fgnt", {31'h0, f_gnt_o}, 32'h1);
    check_val("ct_lgnt0", {31'h0, l_gnt_o}, 32'h0);
    tick();
    l_req_i = 1'b0;
    check_val("ct_lgnt", {31'h0, l_gnt_o}, 32'h1);
    check_val("ct_idx", {27'h0, mem_addr_o}, 32'h2);
    check_val("ct_frd", f_rdata_o, 32'h1000_0000);
    tick();
    check_val("ct_lrv", {31'h0, l_rvalid_o}, 32'h1);
    check_val("ct_lrd", l_rdata_o, 32'h1000_0002);
    check_val("ct_lerr", {31'h0, l_err_o}, 32'h0);
    tick();

    // Locked loader burst of four writes while fetch waits.
    l_req_i = 1'b1; l_we_i = 1'b1; l_lock_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      l_addr_i = 32'h0040_0000 + 32'(4 * k);
      l_wdata_i = 32'hA5A5_0000 + 32'(k);
      tick();
      if (k == 0) begin
        f_req_i = 1'b1; f_addr_i = 32'h0040_000C;
      end
      check_val($sformatf("bu_lgnt%0d", k), {31'h0, l_gnt_o}, 32'h1);
      check_val($sformatf("bu_fgnt%0d", k), {31'h0, f_gnt_o}, 32'h0);
      check_val($sformatf("bu_we%0d", k), {31'h0, mem_we_o}, 32'h1);
      check_val($sformatf("bu_idx%0d", k), {27'h0, mem_addr_o}, 32'(k));
      check_val($sformatf("bu_wd%0d", k), mem_wdata_o, 32'hA5A5_0000 + 32'(k));
      if (k > 0) begin
        check_val($sformatf("bu_lrv%0d", k), {31'h0, l_rvalid_o}, 32'h1);
        check_val($sformatf("bu_lrd%0d", k), l_rdata_o, 32'h0);
      end
    end
    l_req_i = 1'b0; l_lock_i = 1'b0; l_we_i = 1'b0;
    tick();
    f_req_i = 1'b0;
    check_val("bu_fgnt", {31'h0, f_gnt_o}, 32'h1);
    check_val("bu_fidx", {27'h0, mem_addr_o}, 32'h3);
    tick();
    check_val("bu_frv", {31'h0, f_rvalid_o}, 32'h1);
    check_val("bu_frd", f_rdata_o, 32'hA5A5_0003);
    tick();

    // Fetch address errors: misaligned, below base, past end.
    fetch("er_mis", 32'h0040_0002, 5'd0, 32'h0, 1'b1);
    fetch("er_low", 32'h003F_FFFC, 5'd0, 32'h0, 1'b1);
    fetch("er_high", 32'h0040_0080, 5'd0, 32'h0, 1'b1);

    // Errored loader write must not touch memory (wrapped index would be 0).
    pulse_cnt = we_count;
    l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 32'h0040_0080; l_wdata_i = 32'hDEAD_BEEF;
    tick();
    l_req_i = 1'b0; l_we_i = 1'b0;
    check_val("ew_gnt", {31'h0, l_gnt_o}, 32'h1);
    check_val("ew_we", {31'h0, mem_we_o}, 32'h0);
    tick();
    check_val("ew_rv", {31'h0, l_rvalid_o}, 32'h1);
    check_val("ew_err", {31'h0, l_err_o}, 32'h1);
    check_val("ew_rd", l_rdata_o, 32'h0);
    check_val("ew_nowr", 32'(we_count - pulse_cnt), 32'h0);
    l_req_i = 1'b1; l_addr_i = 32'h0040_0000;
    tick();
    l_req_i = 1'b0;
    tick();
    check_val("ew_rb_rv", {31'h0, l_rvalid_o}, 32'h1);
    check_val("ew_rb", l_rdata_o, 32'hA5A5_0000);
    tick();

    // Idle: nothing should pulse for ten cycles.
    idle_inputs();
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (f_gnt_o || l_gnt_o || f_rvalid_o || l_rvalid_o || mem_we_o || mem_addr_o != 5'd0)
        pulse_cnt++;
    end
    check_val("idle_quiet", 32'(pulse_cnt), 32'h0);
    check_all_zero("idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
